// File: rtl/elixirchip_es1_spu_op_or_reduce.sv
// OR-reduces every WINDOW valid samples into one result word behind a LATENCY-deep cke-gated pipe.
// Optional: ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN flushes cleared partial windows on m_partial.
module elixirchip_es1_spu_op_or_reduce #(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter int    WINDOW     = 4,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_valid,
    input  logic  s_clear,
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
    output logic  m_partial,
`endif
    output data_t m_data,
    output logic  m_valid
);

    localparam int CNT_BITS = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WINDOW - 1);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("LATENCY must be within 1..8");
    end
    if (WINDOW < 1) begin : g_bad_window
        $error("WINDOW must be at least 1");
    end
    if (DEVICE == "") begin : g_bad_device
        $error("DEVICE must not be empty");
    end
    if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
        $error("SIMULATION must be \"true\" or \"false\"");
    end
    if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
        $error("DEBUG must be \"true\" or \"false\"");
    end

    data_t               acc;
    data_t               acc_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;
    data_t               emit_data;
    logic                emit_valid;
    logic                emit_partial;

    data_t pipe_data    [LATENCY];
    logic  pipe_valid   [LATENCY];
    logic  pipe_partial [LATENCY];

    always_comb begin
        acc_next     = acc;
        cnt_next     = cnt;
        emit_data    = '0;
        emit_valid   = 1'b0;
        emit_partial = 1'b0;
        if (s_clear) begin
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
            if (cnt != '0 || s_valid) begin
                emit_data    = acc | (s_valid ? s_data : '0);
                emit_valid   = 1'b1;
                emit_partial = 1'b1;
            end
`endif
            acc_next = '0;
            cnt_next = '0;
        end else if (s_valid) begin
            if (cnt == CNT_LAST) begin
                emit_data  = acc | s_data;
                emit_valid = 1'b1;
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                acc_next = acc | s_data;
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // Stage 0 loads on the completing sample edge, so the result is visible LATENCY edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i]    <= '0;
                pipe_valid[i]   <= 1'b0;
                pipe_partial[i] <= 1'b0;
            end
        end else if (cke) begin
            acc             <= acc_next;
            cnt             <= cnt_next;
            pipe_data[0]    <= emit_data;
            pipe_valid[0]   <= emit_valid;
            pipe_partial[0] <= emit_partial;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_data[i]    <= pipe_data[i-1];
                pipe_valid[i]   <= pipe_valid[i-1];
                pipe_partial[i] <= pipe_partial[i-1];
            end
        end
    end

    assign m_data  = pipe_data[LATENCY-1];
    assign m_valid = pipe_valid[LATENCY-1];
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
    assign m_partial = pipe_partial[LATENCY-1];
`else
    logic unused_partial;
    assign unused_partial = pipe_partial[LATENCY-1];
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_or_reduce.sv
// Bench: two instances (LATENCY=1 and LATENCY=3) share one stimulus; a reference model
// pushes expected results with their due cke-edge into per-instance queues.
module tb_elixirchip_es1_spu_op_or_reduce;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_clear;
    logic [7:0] m_data1, m_data3;
    logic       m_valid1, m_valid3;
    logic       m_partial1, m_partial3;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_or_reduce #(.LATENCY(1), .DATA_BITS(8), .WINDOW(4)) dut1 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .s_clear(s_clear),
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
        .m_partial(m_partial1),
`endif
        .m_data(m_data1), .m_valid(m_valid1)
    );

    elixirchip_es1_spu_op_or_reduce #(.LATENCY(3), .DATA_BITS(8), .WINDOW(4)) dut3 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .s_clear(s_clear),
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
        .m_partial(m_partial3),
`endif
        .m_data(m_data3), .m_valid(m_valid3)
    );

`ifndef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
    assign m_partial1 = 1'b0;
    assign m_partial3 = 1'b0;
`endif

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         partial;
    } exp_t;

    exp_t       q1[$];
    exp_t       q3[$];
    int         checks = 0;
    int         errors = 0;
    int         ke = 0;
    logic [7:0] macc = '0;
    int         mcnt = 0;
    int         n1 = 0;
    logic [7:0] last1 = '0;
    int         base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit v, input logic [7:0] d, input bit c);
        bit         emit = 1'b0;
        bit         part = 1'b0;
        logic [7:0] r = '0;
        if (c) begin
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
            if (mcnt != 0 || v) begin
                emit = 1'b1;
                part = 1'b1;
                r    = macc | (v ? d : 8'h00);
            end
`endif
            macc = '0;
            mcnt = 0;
        end else if (v) begin
            r = macc | d;
            if (mcnt == 3) begin
                emit = 1'b1;
                macc = '0;
                mcnt = 0;
            end else begin
                macc = r;
                mcnt++;
            end
        end
        if (emit) begin
            q1.push_back('{due: ke, data: r, partial: part});
            q3.push_back('{due: ke + 2, data: r, partial: part});
        end
    endtask

    task automatic check_outputs();
        bit         ev1, ev3;
        logic [7:0] ed1, ed3;
        bit         ep1, ep3;
        ev1 = (q1.size() > 0) && (q1[0].due == ke);
        ev3 = (q3.size() > 0) && (q3[0].due == ke);
        ed1 = ev1 ? q1[0].data : 8'h00;
        ed3 = ev3 ? q3[0].data : 8'h00;
        ep1 = ev1 ? q1[0].partial : 1'b0;
        ep3 = ev3 ? q3[0].partial : 1'b0;
        chk("lat1_valid", 32'(m_valid1), 32'(ev1));
        chk("lat1_data", 32'(m_data1), 32'(ed1));
        chk("lat3_valid", 32'(m_valid3), 32'(ev3));
        chk("lat3_data", 32'(m_data3), 32'(ed3));
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
        chk("lat1_partial", 32'(m_partial1), 32'(ep1));
        chk("lat3_partial", 32'(m_partial3), 32'(ep3));
`endif
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit c, input bit k);
        s_valid = v;
        s_data  = d;
        s_clear = c;
        cke     = k;
        @(posedge clk);
        if (k) begin
            ke++;
            model(v, d, c);
        end
        #1;
        while (q1.size() > 0 && q1[0].due < ke) void'(q1.pop_front());
        while (q3.size() > 0 && q3[0].due < ke) void'(q3.pop_front());
        check_outputs();
        if (k && m_valid1) begin
            n1++;
            last1 = m_data1;
        end
        s_valid = 1'b0;
        s_clear = 1'b0;
        cke     = 1'b1;
    endtask

    initial begin
        reset = 1'b1; cke = 1'b0; s_data = '0; s_valid = 1'b0; s_clear = 1'b0;
        #1;
        chk("reset_data", 32'(m_data1), 32'h0);
        chk("reset_valid", 32'(m_valid1), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset between edges while a result is in flight and a window is half full.
        step(1, 8'h80, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1);
        step(1, 8'h04, 0, 1); step(1, 8'h04, 0, 1);
        chk("pre_reset_lat3_valid", 32'(m_valid3), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_lat1_data", 32'(m_data1), 32'h0);
        chk("async_reset_lat1_valid", 32'(m_valid1), 32'h0);
        chk("async_reset_lat3_data", 32'(m_data3), 32'h0);
        chk("async_reset_lat3_valid", 32'(m_valid3), 32'h0);
        q1.delete(); q3.delete(); macc = '0; mcnt = 0;
        @(negedge clk);
        reset = 1'b0;
        base = n1;
        step(1, 8'h01, 0, 1); step(1, 8'h01, 0, 1); step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
        chk("t1_result", 32'(last1), 32'h03);
        step(0, 8'h00, 0, 1);
        chk("t1_count", 32'(n1 - base), 32'd1);

        // Consecutive burst, then the same burst with cke held low mid-window.
        base = n1;
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h04, 0, 1); step(1, 8'h08, 0, 1);
        chk("t2_result", 32'(last1), 32'h0F);
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
        step(1, 8'hFF, 0, 0); step(1, 8'hFF, 0, 0); step(1, 8'hFF, 0, 0);
        step(1, 8'h04, 0, 1); step(1, 8'h08, 0, 1);
        step(0, 8'h00, 0, 0);
        chk("t2_held_valid", 32'(m_valid1), 32'h1);
        chk("t2_held_result", 32'(last1), 32'h0F);
        step(0, 8'h00, 0, 1);
        chk("t2_count", 32'(n1 - base), 32'd2);

        // Clear mid-window.
        base = n1;
        step(1, 8'h10, 0, 1); step(1, 8'h20, 0, 1); step(0, 8'h00, 1, 1);
        step(1, 8'h01, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h80, 0, 1);
        chk("t3_result", 32'(last1), 32'h81);
        step(0, 8'h00, 0, 1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
        chk("t3_count", 32'(n1 - base), 32'd2);
`else
        chk("t3_count", 32'(n1 - base), 32'd1);
`endif

        // Clear beats a same-edge valid sample at cnt=0.
        base = n1;
        step(1, 8'hFF, 1, 1);
        step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1); step(1, 8'h00, 0, 1);
        chk("t4_result", 32'(last1), 32'h00);
        step(0, 8'h00, 0, 1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_OR_REDUCE_PARTIAL_EN
        chk("t4_count", 32'(n1 - base), 32'd2);
`else
        chk("t4_count", 32'(n1 - base), 32'd1);
`endif

        // Valid on alternate cycles.
        base = n1;
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(1 << i), 0, 1);
            if (i == 3) chk("t5_first", 32'(last1), 32'h0F);
            step(0, 8'hAA, 0, 1);
        end
        chk("t5_second", 32'(last1), 32'hF0);
        chk("t5_count", 32'(n1 - base), 32'd2);

        // Continuous windows; LATENCY=3 timing is checked by the scoreboard each step.
        base = n1;
        for (int i = 0; i < 12; i++) step(1, 8'($urandom), 0, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
        chk("t6_count", 32'(n1 - base), 32'd3);

        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) != 0);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
